// File: rtl/pixel_frame_gen.sv
// pixel_frame_gen: raster test-pattern source, dark rectangle on bright background
// Ports:
//   iCLK, iRST          clock, asynchronous active-low reset
//   iSTART              start one frame (honoured only in IDLE)
//   iCONT               chain the next frame directly after V_BLANK
//   iXSTART..iYEND      inclusive object window, latched at frame start
//   oDVAL, oDATA        pixel valid and 10-bit pixel value
//   oX, oY              coordinates of the presented pixel
//   oBUSY               high from frame start through the end of V_BLANK
//   oFRAME_DONE         one-cycle pulse on the last V_BLANK cycle
module pixel_frame_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK = 16,
    parameter int V_BLANK = 32,
    parameter logic [9:0] BG_LEVEL = 10'h3FF,
    parameter logic [9:0] OBJ_LEVEL = 10'h000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iCONT,
    input  logic [15:0] iXSTART,
    input  logic [15:0] iXEND,
    input  logic [15:0] iYSTART,
    input  logic [15:0] iYEND,
    output logic        oDVAL,
    output logic [9:0]  oDATA,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic        oBUSY,
    output logic        oFRAME_DONE
);
    localparam int HW = H_BLANK > 1 ? $clog2(H_BLANK) : 1;
    localparam int VW = V_BLANK > 1 ? $clog2(V_BLANK) : 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;
    state_t state;
    logic [15:0] xStart, xEnd, yStart, yEnd;
    logic [HW-1:0] hCnt;
    logic [VW-1:0] vCnt;
    logic lastX, lastY, lastH, lastV, launch;
    function automatic logic [9:0] pix(input logic [15:0] x, y, xs, xe, ys, ye);
        return (x >= xs && x <= xe && y >= ys && y <= ye) ? OBJ_LEVEL : BG_LEVEL;
    endfunction
    assign lastX = oX == 16'(H_ACTIVE - 1);
    assign lastY = oY == 16'(V_ACTIVE - 1);
    assign lastH = int'(hCnt) == H_BLANK - 1;
    assign lastV = int'(vCnt) == V_BLANK - 1;
    // A frame begins from IDLE on iSTART, or straight out of V_BLANK in continuous mode
    assign launch = (state == IDLE && iSTART) || (state == VBLANK && lastV && iCONT);
    // oDATA is always computed from the coordinates being loaded in the same edge
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= IDLE;
            oDVAL <= 1'b0;
            oDATA <= '0;
            oX <= '0;
            oY <= '0;
            oBUSY <= 1'b0;
            oFRAME_DONE <= 1'b0;
            xStart <= '0;
            xEnd <= '0;
            yStart <= '0;
            yEnd <= '0;
            hCnt <= '0;
            vCnt <= '0;
        end else begin
            oFRAME_DONE <= 1'b0;
            if (launch) begin
                xStart <= iXSTART;
                xEnd <= iXEND;
                yStart <= iYSTART;
                yEnd <= iYEND;
                state <= ACTIVE;
                oDVAL <= 1'b1;
                oBUSY <= 1'b1;
                oX <= '0;
                oY <= '0;
                oDATA <= pix(16'd0, 16'd0, iXSTART, iXEND, iYSTART, iYEND);
            end else begin
                case (state)
                    ACTIVE: begin
                        if (lastX) begin
                            oDVAL <= 1'b0;
                            hCnt <= '0;
                            vCnt <= '0;
                            oFRAME_DONE <= lastY && V_BLANK == 1;
                            state <= lastY ? VBLANK : HBLANK;
                        end else begin
                            oX <= oX + 16'd1;
                            oDATA <= pix(oX + 16'd1, oY, xStart, xEnd, yStart, yEnd);
                        end
                    end
                    HBLANK: begin
                        if (lastH) begin
                            state <= ACTIVE;
                            oDVAL <= 1'b1;
                            oX <= '0;
                            oY <= oY + 16'd1;
                            oDATA <= pix(16'd0, oY + 16'd1, xStart, xEnd, yStart, yEnd);
                        end else begin
                            hCnt <= hCnt + 1'b1;
                        end
                    end
                    VBLANK: begin
                        if (lastV) begin
                            state <= IDLE;
                            oBUSY <= 1'b0;
                        end else begin
                            vCnt <= vCnt + 1'b1;
                            // pulse lands on the cycle where vCnt reaches V_BLANK-1
                            oFRAME_DONE <= int'(vCnt) == V_BLANK - 2;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pixel_frame_gen.sv
// tb_pixel_frame_gen: self-checking bench for pixel_frame_gen on a reduced raster
module tb_pixel_frame_gen;
    localparam int HA = 8, VA = 6, HB = 3, VB = 4;
    logic iCLK = 1'b0, iRST = 1'b1, iSTART = 1'b0, iCONT = 1'b0;
    logic [15:0] iXSTART = '0, iXEND = '0, iYSTART = '0, iYEND = '0;
    logic oDVAL, oBUSY, oFRAME_DONE;
    logic [9:0] oDATA;
    logic [15:0] oX, oY;
    int total = 0, bad = 0;
    typedef struct {logic [15:0] xs, xe, ys, ye;} win_t;
    typedef struct {win_t w; int zeros; int fx; int fy;} vec_t;
    typedef struct {logic dval; logic [15:0] x, y; logic [9:0] d; logic done;} exp_t;
    vec_t tv[6];
    always #5 iCLK = ~iCLK;
    pixel_frame_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iCONT(iCONT),
        .iXSTART(iXSTART), .iXEND(iXEND), .iYSTART(iYSTART), .iYEND(iYEND),
        .oDVAL(oDVAL), .oDATA(oDATA), .oX(oX), .oY(oY), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE)
    );
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, a, e, $time);
        end
    endtask
    task automatic setWin(input win_t w);
        iXSTART = w.xs;
        iXEND = w.xe;
        iYSTART = w.ys;
        iYEND = w.ye;
    endtask
    function automatic win_t rw();
        win_t w;
        w.xs = 16'($urandom_range(0, 12));
        w.xe = 16'($urandom_range(0, 12));
        w.ys = 16'($urandom_range(0, 9));
        w.ye = 16'($urandom_range(0, 9));
        return w;
    endfunction
    task automatic startFrame(input win_t w, input logic c);
        @(negedge iCLK);
        setWin(w);
        iSTART = 1'b1;
        iCONT = c;
    endtask
    task automatic idleCheck();
        @(negedge iCLK);
        chk("idle_busy", 32'(oBUSY), 0);
        chk("idle_dval", 32'(oDVAL), 0);
        chk("idle_done", 32'(oFRAME_DONE), 0);
    endtask
    // Expected frame: raster of HAxVA pixels, HB idle after every row but the last,
    // VB idle at the end with the done pulse on the final one.
    task automatic frame(input win_t w, input win_t nw, input bit noise, input logic c,
                         output int zeros, output int fx, output int fy);
        exp_t q[$];
        exp_t e;
        int dones = 0;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                e.dval = 1'b1;
                e.x = 16'(x);
                e.y = 16'(y);
                e.d = (x >= int'(w.xs) && x <= int'(w.xe) && y >= int'(w.ys) && y <= int'(w.ye)) ? 10'h000 : 10'h3FF;
                e.done = 1'b0;
                q.push_back(e);
            end
            e.dval = 1'b0;
            if (y < VA - 1) repeat (HB) q.push_back(e);
        end
        repeat (VB) q.push_back(e);
        q[q.size()-1].done = 1'b1;
        zeros = 0;
        fx = -1;
        fy = -1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge iCLK);
            chk("dval", 32'(oDVAL), 32'(q[i].dval));
            chk("busy", 32'(oBUSY), 1);
            chk("done", 32'(oFRAME_DONE), 32'(q[i].done));
            if (q[i].dval) begin
                chk("x", 32'(oX), 32'(q[i].x));
                chk("y", 32'(oY), 32'(q[i].y));
                chk("data", 32'(oDATA), 32'(q[i].d));
            end
            if (oFRAME_DONE) dones++;
            if (oDVAL && oDATA == 10'h000) begin
                if (zeros == 0) begin
                    fx = int'(oX);
                    fy = int'(oY);
                end
                zeros++;
            end
            if (i == q.size() - 1) begin
                setWin(nw);
                iSTART = 1'b0;
                iCONT = c;
            end else if (noise) begin
                iSTART = 1'($urandom_range(0, 1));
                setWin(rw());
            end else begin
                iSTART = 1'b0;
            end
        end
        chk("done_count", 32'(dones), 1);
    endtask
    initial begin
        int z, fx, fy, n;
        bit hit, sawDone;
        win_t w, nw, w1, w2;
        logic c;
        tv[0] = '{'{16'd2, 16'd5, 16'd1, 16'd3}, 12, 2, 1};
        tv[1] = '{'{16'd6, 16'd20, 16'd4, 16'd10}, 4, 6, 4};
        tv[2] = '{'{16'd500, 16'd100, 16'd0, 16'd5}, 0, -1, -1};
        tv[3] = '{'{16'd0, 16'd7, 16'd0, 16'd5}, 48, 0, 0};
        tv[4] = '{'{16'd7, 16'd7, 16'd5, 16'd5}, 1, 7, 5};
        tv[5] = '{'{16'd3, 16'd3, 16'd0, 16'd9}, 6, 3, 0};
        #3 iRST = 1'b0;
        repeat (2) @(negedge iCLK);
        chk("rst_dval", 32'(oDVAL), 0);
        chk("rst_data", 32'(oDATA), 0);
        chk("rst_x", 32'(oX), 0);
        chk("rst_y", 32'(oY), 0);
        chk("rst_busy", 32'(oBUSY), 0);
        chk("rst_done", 32'(oFRAME_DONE), 0);
        iRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            startFrame(tv[i].w, 1'b0);
            frame(tv[i].w, tv[i].w, 1'b0, 1'b0, z, fx, fy);
            chk("tab_zeros", 32'(z), 32'(tv[i].zeros));
            chk("tab_firstx", 32'(fx), 32'(tv[i].fx));
            chk("tab_firsty", 32'(fy), 32'(tv[i].fy));
            idleCheck();
        end
        // iSTART hammered and window scrambled while busy
        startFrame(tv[0].w, 1'b0);
        frame(tv[0].w, tv[0].w, 1'b1, 1'b0, z, fx, fy);
        chk("busy_start_zeros", 32'(z), 12);
        idleCheck();
        // chained frames with iSTART and iCONT together in IDLE
        w1 = '{16'd1, 16'd2, 16'd1, 16'd2};
        w2 = '{16'd4, 16'd6, 16'd2, 16'd5};
        startFrame(w1, 1'b1);
        frame(w1, w2, 1'b1, 1'b1, z, fx, fy);
        chk("chain1_zeros", 32'(z), 4);
        frame(w2, w2, 1'b0, 1'b0, z, fx, fy);
        chk("chain2_zeros", 32'(z), 12);
        chk("chain2_firstx", 32'(fx), 4);
        idleCheck();
        // random windows, random chaining
        w = rw();
        startFrame(w, 1'b0);
        for (int k = 0; k < 8; k++) begin
            nw = rw();
            c = (k == 7) ? 1'b0 : 1'($urandom_range(0, 1));
            frame(w, nw, 1'b1, c, z, fx, fy);
            if (!c) begin
                idleCheck();
                startFrame(nw, 1'b0);
            end
            w = nw;
        end
        frame(w, w, 1'b0, 1'b0, z, fx, fy);
        idleCheck();
        // asynchronous reset mid-frame
        startFrame(tv[3].w, 1'b0);
        hit = 0;
        sawDone = 0;
        n = 0;
        while (n < 200 && !hit) begin
            @(negedge iCLK);
            iSTART = 1'b0;
            if (oFRAME_DONE) sawDone = 1;
            if (oDVAL && oX == 16'd4 && oY == 16'd3) hit = 1;
            n++;
        end
        chk("reach_mid", 32'(hit), 1);
        #2 iRST = 1'b0;
        #1;
        chk("arst_dval", 32'(oDVAL), 0);
        chk("arst_data", 32'(oDATA), 0);
        chk("arst_x", 32'(oX), 0);
        chk("arst_y", 32'(oY), 0);
        chk("arst_busy", 32'(oBUSY), 0);
        repeat (3) begin
            @(negedge iCLK);
            if (oFRAME_DONE) sawDone = 1;
        end
        iRST = 1'b1;
        repeat (VB + 2) begin
            @(negedge iCLK);
            if (oFRAME_DONE) sawDone = 1;
        end
        chk("arst_no_done", 32'(sawDone), 0);
        chk("arst_idle", 32'(oBUSY), 0);
        startFrame(tv[0].w, 1'b0);
        frame(tv[0].w, tv[0].w, 1'b0, 1'b0, z, fx, fy);
        chk("post_rst_zeros", 32'(z), 12);
        idleCheck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
